// File: rtl/id_decode_stage_pkg.sv
// Shared decode constants: opcodes, funct3 codes, ALU/mem/dest/branch encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Branch codes are used only when ID_BRANCH_DECODE_EN is defined.
package id_decode_stage_pkg;

  localparam int INSTR_W_DEF    = 32;
  localparam int WORD_W_DEF     = 32;
  localparam int PC_W_DEF       = 32;
  localparam int ALU_OP_W_DEF   = 4;
  localparam int REG_ADDR_W_DEF = 5;

  localparam int ALU_SRC_A_W = 2;
  localparam int ALU_SRC_B_W = 2;
  localparam int MEM_OP_W    = 4;
  localparam int DEST_SRC_W  = 2;
  localparam int BR_OP_W     = 3;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;
  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  // ALU_ADD is zero so that the reset value of the op register is ADD.
  typedef enum logic [ALU_OP_W_DEF-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [ALU_SRC_A_W-1:0] {
    ALU_A_ZERO = 2'd0,
    ALU_A_XPR  = 2'd1,
    ALU_A_PC   = 2'd2
  } alu_src_a_e;

  typedef enum logic [ALU_SRC_B_W-1:0] {
    ALU_B_ZERO = 2'd0,
    ALU_B_XPR  = 2'd1,
    ALU_B_IMM  = 2'd2
  } alu_src_b_e;

  typedef enum logic [MEM_OP_W-1:0] {
    MEM_OP_NOP       = 4'd0,
    MEM_OP_RD_BYTE   = 4'd1,
    MEM_OP_RD_HALF   = 4'd2,
    MEM_OP_RD_WORD   = 4'd3,
    MEM_OP_RD_BYTE_U = 4'd4,
    MEM_OP_RD_HALF_U = 4'd5,
    MEM_OP_WR_BYTE   = 4'd6,
    MEM_OP_WR_HALF   = 4'd7,
    MEM_OP_WR_WORD   = 4'd8
  } mem_op_e;

  typedef enum logic [DEST_SRC_W-1:0] {
    DEST_SRC_NONE = 2'd0,
    DEST_SRC_ALU  = 2'd1,
    DEST_SRC_MEM  = 2'd2
  } dest_src_e;

  typedef enum logic [BR_OP_W-1:0] {
    BR_OP_NONE = 3'd0,
    BR_OP_BEQ  = 3'd1,
    BR_OP_BNE  = 3'd2,
    BR_OP_BLT  = 3'd3,
    BR_OP_BGE  = 3'd4,
    BR_OP_BLTU = 3'd5,
    BR_OP_BGEU = 3'd6
  } br_op_e;

endpackage

// File: rtl/id_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// Latency: n/a (wiring only).
// Backpressure: valid/ready both sides; out_br_op exists only with ID_BRANCH_DECODE_EN.
interface id_decode_stage_if
  import id_decode_stage_pkg::*;
#(
  parameter int INSTR_W    = INSTR_W_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int PC_W       = PC_W_DEF,
  parameter int ALU_OP_W   = ALU_OP_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
);
  logic                   in_valid;
  logic                   in_ready;
  logic [INSTR_W-1:0]     in_instr;
  logic [PC_W-1:0]        in_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [PC_W-1:0]        out_pc;
  logic [ALU_OP_W-1:0]    out_alu_op;
  logic [WORD_W-1:0]      out_imm;
  logic [ALU_SRC_A_W-1:0] out_alu_a_src;
  logic [ALU_SRC_B_W-1:0] out_alu_b_src;
  logic [MEM_OP_W-1:0]    out_mem_op;
  logic [DEST_SRC_W-1:0]  out_dest_src;
  logic [REG_ADDR_W-1:0]  out_rs1;
  logic [REG_ADDR_W-1:0]  out_rs2;
  logic [REG_ADDR_W-1:0]  out_rd;
  logic                   out_illegal;
`ifdef ID_BRANCH_DECODE_EN
  logic [BR_OP_W-1:0]     out_br_op;
`endif

  // Environment side: fetch drives instructions, execute drives out_ready.
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_alu_op, out_imm, out_alu_a_src,
           out_alu_b_src, out_mem_op, out_dest_src, out_rs1, out_rs2, out_rd,
`ifdef ID_BRANCH_DECODE_EN
    input  out_br_op,
`endif
    input  out_illegal
  );

  // Decode stage side.
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_alu_op, out_imm, out_alu_a_src,
           out_alu_b_src, out_mem_op, out_dest_src, out_rs1, out_rs2, out_rd,
`ifdef ID_BRANCH_DECODE_EN
    output out_br_op,
`endif
    output out_illegal
  );
endinterface

// File: rtl/id_decode_stage_comb.sv
// Pure combinational RV32I decode of one instruction into the EX control bundle.
// Latency: 0 cycles (no state).
// Backpressure: none; ID_BRANCH_DECODE_EN adds BRANCH decoding and br_op.
module id_decode_comb
  import id_decode_stage_pkg::*;
#(
  parameter int INSTR_W    = INSTR_W_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int ALU_OP_W   = ALU_OP_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [INSTR_W-1:0]     instr,
  output logic [ALU_OP_W-1:0]    alu_op,
  output logic [WORD_W-1:0]      imm,
  output logic [ALU_SRC_A_W-1:0] alu_a_src,
  output logic [ALU_SRC_B_W-1:0] alu_b_src,
  output logic [MEM_OP_W-1:0]    mem_op,
  output logic [DEST_SRC_W-1:0]  dest_src,
  output logic [REG_ADDR_W-1:0]  rs1,
  output logic [REG_ADDR_W-1:0]  rs2,
  output logic [REG_ADDR_W-1:0]  rd,
`ifdef ID_BRANCH_DECODE_EN
  output logic [BR_OP_W-1:0]     br_op,
`endif
  output logic                   illegal
);
  opcode_e            opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic signed [11:0] imm_i12;
  logic signed [11:0] imm_s12;
  logic [WORD_W-1:0]  imm_i;
  logic [WORD_W-1:0]  imm_s;

  assign opcode  = opcode_e'(instr[6:0]);
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign imm_i12 = instr[31:20];
  assign imm_s12 = {instr[31:25], instr[11:7]};
  assign imm_i   = WORD_W'(imm_i12);
  assign imm_s   = WORD_W'(imm_s12);
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];

`ifdef ID_BRANCH_DECODE_EN
  logic signed [12:0] imm_b13;
  logic [WORD_W-1:0]  imm_b;
  assign imm_b13 = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_b   = WORD_W'(imm_b13);
`endif

  // Opcode/funct decode; an illegal result forces every control field to its inert value.
  always_comb begin
    alu_op    = ALU_ADD;
    imm       = '0;
    alu_a_src = ALU_A_ZERO;
    alu_b_src = ALU_B_ZERO;
    mem_op    = MEM_OP_NOP;
    dest_src  = DEST_SRC_NONE;
    rd        = instr[11:7];
    illegal   = 1'b0;
`ifdef ID_BRANCH_DECODE_EN
    br_op     = BR_OP_NONE;
`endif
    case (opcode)
      OPC_OP: begin
        alu_a_src = ALU_A_XPR;
        alu_b_src = ALU_B_XPR;
        dest_src  = DEST_SRC_ALU;
        case ({funct7, funct3})
          10'b0000000_000: alu_op = ALU_ADD;
          10'b0000000_001: alu_op = ALU_SLL;
          10'b0000000_010: alu_op = ALU_SLT;
          10'b0000000_011: alu_op = ALU_SLTU;
          10'b0000000_100: alu_op = ALU_XOR;
          10'b0000000_101: alu_op = ALU_SRL;
          10'b0000000_110: alu_op = ALU_OR;
          10'b0000000_111: alu_op = ALU_AND;
          10'b0100000_000: alu_op = ALU_SUB;
          10'b0100000_101: alu_op = ALU_SRA;
          default:         illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        imm       = imm_i;
        alu_a_src = ALU_A_XPR;
        alu_b_src = ALU_B_IMM;
        dest_src  = DEST_SRC_ALU;
        case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          3'b001: begin
            if (funct7 == 7'b0000000) alu_op = ALU_SLL;
            else                      illegal = 1'b1;
          end
          default: begin
            // funct3 101: bit 30 picks arithmetic shift, the rest of funct7 must be zero.
            if (funct7 == 7'b0000000)      alu_op = ALU_SRL;
            else if (funct7 == 7'b0100000) alu_op = ALU_SRA;
            else                           illegal = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        imm       = imm_i;
        alu_a_src = ALU_A_XPR;
        alu_b_src = ALU_B_IMM;
        dest_src  = DEST_SRC_MEM;
        case (funct3)
          FUNCT3_LB:  mem_op = MEM_OP_RD_BYTE;
          FUNCT3_LH:  mem_op = MEM_OP_RD_HALF;
          FUNCT3_LW:  mem_op = MEM_OP_RD_WORD;
          FUNCT3_LBU: mem_op = MEM_OP_RD_BYTE_U;
          FUNCT3_LHU: mem_op = MEM_OP_RD_HALF_U;
          default:    illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        imm       = imm_s;
        alu_a_src = ALU_A_XPR;
        alu_b_src = ALU_B_IMM;
        rd        = '0;
        case (funct3)
          FUNCT3_SB: mem_op = MEM_OP_WR_BYTE;
          FUNCT3_SH: mem_op = MEM_OP_WR_HALF;
          FUNCT3_SW: mem_op = MEM_OP_WR_WORD;
          default:   illegal = 1'b1;
        endcase
      end
`ifdef ID_BRANCH_DECODE_EN
      OPC_BRANCH: begin
        imm       = imm_b;
        alu_op    = ALU_SUB;
        alu_a_src = ALU_A_XPR;
        alu_b_src = ALU_B_XPR;
        rd        = '0;
        case (funct3)
          FUNCT3_BEQ:  br_op = BR_OP_BEQ;
          FUNCT3_BNE:  br_op = BR_OP_BNE;
          FUNCT3_BLT:  br_op = BR_OP_BLT;
          FUNCT3_BGE:  br_op = BR_OP_BGE;
          FUNCT3_BLTU: br_op = BR_OP_BLTU;
          FUNCT3_BGEU: br_op = BR_OP_BGEU;
          default:     illegal = 1'b1;
        endcase
      end
`endif
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      alu_op    = ALU_ADD;
      imm       = '0;
      alu_a_src = ALU_A_ZERO;
      alu_b_src = ALU_B_ZERO;
      mem_op    = MEM_OP_NOP;
      dest_src  = DEST_SRC_NONE;
      rd        = '0;
`ifdef ID_BRANCH_DECODE_EN
      br_op     = BR_OP_NONE;
`endif
    end
  end
endmodule

// File: rtl/id_decode_stage.sv
// Registered IF->EX decode stage with main + one-entry skid register; optional ID_BRANCH_DECODE_EN.
// Latency: 1 cycle from accept to out_valid; 1 instr/cycle sustained.
// Backpressure: in_ready = !skid_valid (register-driven); flush empties both entries next cycle.
module id_decode_stage
  import id_decode_stage_pkg::*;
#(
  parameter int INSTR_W    = INSTR_W_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int PC_W       = PC_W_DEF,
  parameter int ALU_OP_W   = ALU_OP_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  id_decode_stage_if.slave bus
);
  typedef struct packed {
    logic [PC_W-1:0]        pc;
    logic [ALU_OP_W-1:0]    alu_op;
    logic [WORD_W-1:0]      imm;
    logic [ALU_SRC_A_W-1:0] alu_a_src;
    logic [ALU_SRC_B_W-1:0] alu_b_src;
    logic [MEM_OP_W-1:0]    mem_op;
    logic [DEST_SRC_W-1:0]  dest_src;
    logic [REG_ADDR_W-1:0]  rs1;
    logic [REG_ADDR_W-1:0]  rs2;
    logic [REG_ADDR_W-1:0]  rd;
`ifdef ID_BRANCH_DECODE_EN
    logic [BR_OP_W-1:0]     br_op;
`endif
    logic                   illegal;
  } bundle_t;

  bundle_t dec;
  bundle_t main_q;
  bundle_t skid_q;
  logic    main_valid;
  logic    skid_valid;
  logic    accept;
  logic    fire;

  assign dec.pc = bus.in_pc;

  id_decode_comb #(
    .INSTR_W    (INSTR_W),
    .WORD_W     (WORD_W),
    .ALU_OP_W   (ALU_OP_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_decode (
    .instr     (bus.in_instr),
    .alu_op    (dec.alu_op),
    .imm       (dec.imm),
    .alu_a_src (dec.alu_a_src),
    .alu_b_src (dec.alu_b_src),
    .mem_op    (dec.mem_op),
    .dest_src  (dec.dest_src),
    .rs1       (dec.rs1),
    .rs2       (dec.rs2),
    .rd        (dec.rd),
`ifdef ID_BRANCH_DECODE_EN
    .br_op     (dec.br_op),
`endif
    .illegal   (dec.illegal)
  );

  assign accept = bus.in_valid & bus.in_ready;
  assign fire   = main_valid & bus.out_ready;

  // Main/skid occupancy and payload; flush clears both valids and drops any same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (fire || !main_valid) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= accept;
        if (accept) skid_q <= dec;
      end else begin
        main_valid <= accept;
        if (accept) main_q <= dec;
      end
    end else if (accept) begin
      // Main is stalled: park the new bundle so in_ready can drop without losing it.
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign bus.in_ready      = ~skid_valid;
  assign bus.out_valid     = main_valid;
  assign bus.out_pc        = main_q.pc;
  assign bus.out_alu_op    = main_q.alu_op;
  assign bus.out_imm       = main_q.imm;
  assign bus.out_alu_a_src = main_q.alu_a_src;
  assign bus.out_alu_b_src = main_q.alu_b_src;
  assign bus.out_mem_op    = main_q.mem_op;
  assign bus.out_dest_src  = main_q.dest_src;
  assign bus.out_rs1       = main_q.rs1;
  assign bus.out_rs2       = main_q.rs2;
  assign bus.out_rd        = main_q.rd;
  assign bus.out_illegal   = main_q.illegal;
`ifdef ID_BRANCH_DECODE_EN
  assign bus.out_br_op     = main_q.br_op;
`endif
endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: decode vectors, backpressure, flush, resets.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-derived from the instruction encodings.
module tb_id_decode_stage;
  import id_decode_stage_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  int   errors;
  int   checks;

  id_decode_stage_if bus ();

  id_decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    #2;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    checks++; if (bus.out_mem_op !== MEM_OP_NOP || bus.out_dest_src !== DEST_SRC_NONE || bus.out_alu_op !== ALU_ADD)
      begin errors++; $display("FAIL reset_ctrl got mem=%0d dest=%0d alu=%0d exp=0/0/0", bus.out_mem_op, bus.out_dest_src, bus.out_alu_op); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    bus.out_ready = 1'b1;
    send(32'hFFF00093, 32'h100);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got=%0b exp=1", bus.out_valid); end
    checks++; if (bus.out_alu_op !== ALU_ADD) begin errors++; $display("FAIL addi_alu got=%0d exp=%0d", bus.out_alu_op, ALU_ADD); end
    checks++; if (bus.out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got=%h exp=ffffffff", bus.out_imm); end
    checks++; if (bus.out_alu_b_src !== ALU_B_IMM || bus.out_alu_a_src !== ALU_A_XPR)
      begin errors++; $display("FAIL addi_src got a=%0d b=%0d exp a=1 b=2", bus.out_alu_a_src, bus.out_alu_b_src); end
    checks++; if (bus.out_rd !== 5'd1 || bus.out_dest_src !== DEST_SRC_ALU)
      begin errors++; $display("FAIL addi_rd got rd=%0d dest=%0d exp rd=1 dest=1", bus.out_rd, bus.out_dest_src); end
    checks++; if (bus.out_illegal !== 1'b0 || bus.out_pc !== 32'h100)
      begin errors++; $display("FAIL addi_pc got ill=%0b pc=%h exp ill=0 pc=100", bus.out_illegal, bus.out_pc); end
  endtask

  task automatic test_store_load();
    send(32'hFE20AE23, 32'h104);
    checks++; if (bus.out_mem_op !== MEM_OP_WR_WORD) begin errors++; $display("FAIL sw_mem got=%0d exp=%0d", bus.out_mem_op, MEM_OP_WR_WORD); end
    checks++; if (bus.out_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL sw_imm got=%h exp=fffffffc", bus.out_imm); end
    checks++; if (bus.out_dest_src !== DEST_SRC_NONE || bus.out_rd !== 5'd0)
      begin errors++; $display("FAIL sw_dest got dest=%0d rd=%0d exp 0/0", bus.out_dest_src, bus.out_rd); end
    checks++; if (bus.out_rs1 !== 5'd1 || bus.out_rs2 !== 5'd2)
      begin errors++; $display("FAIL sw_rs got rs1=%0d rs2=%0d exp 1/2", bus.out_rs1, bus.out_rs2); end
    send(32'h0081D283, 32'h108);
    checks++; if (bus.out_mem_op !== MEM_OP_RD_HALF_U) begin errors++; $display("FAIL lhu_mem got=%0d exp=%0d", bus.out_mem_op, MEM_OP_RD_HALF_U); end
    checks++; if (bus.out_imm !== 32'h8) begin errors++; $display("FAIL lhu_imm got=%h exp=8", bus.out_imm); end
    checks++; if (bus.out_dest_src !== DEST_SRC_MEM || bus.out_rd !== 5'd5 || bus.out_rs1 !== 5'd3)
      begin errors++; $display("FAIL lhu_regs got dest=%0d rd=%0d rs1=%0d exp 2/5/3", bus.out_dest_src, bus.out_rd, bus.out_rs1); end
  endtask

  task automatic test_alu_variants();
    // SUB x3,x1,x2
    send(32'h402081B3, 32'h10C);
    checks++; if (bus.out_alu_op !== ALU_SUB || bus.out_alu_b_src !== ALU_B_XPR || bus.out_imm !== 32'h0)
      begin errors++; $display("FAIL sub_dec got alu=%0d b=%0d imm=%h exp 1/1/0", bus.out_alu_op, bus.out_alu_b_src, bus.out_imm); end
    checks++; if (bus.out_rd !== 5'd3 || bus.out_dest_src !== DEST_SRC_ALU)
      begin errors++; $display("FAIL sub_rd got rd=%0d dest=%0d exp 3/1", bus.out_rd, bus.out_dest_src); end
    // SRAI x4,x4,3
    send(32'h40325213, 32'h110);
    checks++; if (bus.out_alu_op !== ALU_SRA || bus.out_imm !== 32'h403)
      begin errors++; $display("FAIL srai_dec got alu=%0d imm=%h exp 7/403", bus.out_alu_op, bus.out_imm); end
    // SLLI with funct7=0100000
    send(32'h40321213, 32'h114);
    checks++; if (bus.out_illegal !== 1'b1 || bus.out_rd !== 5'd0 || bus.out_dest_src !== DEST_SRC_NONE)
      begin errors++; $display("FAIL slli_bad got ill=%0b rd=%0d dest=%0d exp 1/0/0", bus.out_illegal, bus.out_rd, bus.out_dest_src); end
    // funct7=0000001 (MUL) is not RV32I
    send(32'h022080B3, 32'h118);
    checks++; if (bus.out_illegal !== 1'b1 || bus.out_alu_op !== ALU_ADD)
      begin errors++; $display("FAIL mul_bad got ill=%0b alu=%0d exp 1/0", bus.out_illegal, bus.out_alu_op); end
    // BEQ x1,x2,+8
    send(32'h00208463, 32'h11C);
`ifdef ID_BRANCH_DECODE_EN
    checks++; if (bus.out_illegal !== 1'b0 || bus.out_br_op !== BR_OP_BEQ || bus.out_imm !== 32'h8 || bus.out_alu_op !== ALU_SUB)
      begin errors++; $display("FAIL beq_dec got ill=%0b br=%0d imm=%h alu=%0d exp 0/1/8/1", bus.out_illegal, bus.out_br_op, bus.out_imm, bus.out_alu_op); end
`else
    checks++; if (bus.out_illegal !== 1'b1 || bus.out_imm !== 32'h0)
      begin errors++; $display("FAIL beq_bad got ill=%0b imm=%h exp 1/0", bus.out_illegal, bus.out_imm); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc [3];
    logic [4:0]  exp_rd [3];
    exp_pc[0] = 32'h200; exp_pc[1] = 32'h204; exp_pc[2] = 32'h208;
    exp_rd[0] = 5'd1;    exp_rd[1] = 5'd2;    exp_rd[2] = 5'd3;
    drain();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1; bus.in_instr = 32'h00100093; bus.in_pc = exp_pc[0];
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_pc !== exp_pc[0])
      begin errors++; $display("FAIL bp_first got v=%0b rdy=%0b pc=%h exp 1/1/200", bus.out_valid, bus.in_ready, bus.out_pc); end
    bus.in_instr = 32'h00100113; bus.in_pc = exp_pc[1];
    tick();
    checks++; if (bus.in_ready !== 1'b0 || bus.out_pc !== exp_pc[0])
      begin errors++; $display("FAIL bp_skid got rdy=%0b pc=%h exp 0/200", bus.in_ready, bus.out_pc); end
    bus.in_instr = 32'h00100193; bus.in_pc = exp_pc[2];
    tick();
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[0])
      begin errors++; $display("FAIL bp_hold got rdy=%0b v=%0b pc=%h exp 0/1/200", bus.in_ready, bus.out_valid, bus.out_pc); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_pc !== exp_pc[1] || bus.out_rd !== exp_rd[1] || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_drain1 got pc=%h rd=%0d rdy=%0b exp 204/2/1", bus.out_pc, bus.out_rd, bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[2] || bus.out_rd !== exp_rd[2])
      begin errors++; $display("FAIL bp_drain2 got v=%0b pc=%h rd=%0d exp 1/208/3", bus.out_valid, bus.out_pc, bus.out_rd); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got v=%0b exp 0", bus.out_valid); end
  endtask

  task automatic test_illegal_flush();
    drain();
    send(32'h12345FFF, 32'h400);
    checks++; if (bus.out_illegal !== 1'b1 || bus.out_mem_op !== MEM_OP_NOP || bus.out_rd !== 5'd0 || bus.out_imm !== 32'h0)
      begin errors++; $display("FAIL ill_dec got ill=%0b mem=%0d rd=%0d imm=%h exp 1/0/0/0", bus.out_illegal, bus.out_mem_op, bus.out_rd, bus.out_imm); end
    bus.out_ready = 1'b0;
    send(32'h00100093, 32'h500);
    checks++; if (bus.in_ready !== 1'b0 || bus.out_pc !== 32'h400)
      begin errors++; $display("FAIL fl_full got rdy=%0b pc=%h exp 0/400", bus.in_ready, bus.out_pc); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL fl_clear got v=%0b rdy=%0b exp 0/1", bus.out_valid, bus.in_ready); end
    flush = 1'b1;
    send(32'h00100093, 32'h600);
    flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_drop got v=%0b exp 0", bus.out_valid); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_ghost got v=%0b pc=%h exp v=0", bus.out_valid, bus.out_pc); end
    send(32'h00500293, 32'h700);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h700 || bus.out_rd !== 5'd5)
      begin errors++; $display("FAIL fl_recover got v=%0b pc=%h rd=%0d exp 1/700/5", bus.out_valid, bus.out_pc, bus.out_rd); end
  endtask

  task automatic test_reset_midstream();
    drain();
    bus.out_ready = 1'b0;
    send(32'hFFF00093, 32'h800);
    send(32'h0081D283, 32'h804);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mr_full got rdy=%0b exp 0", bus.in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL mr_async got v=%0b rdy=%0b exp 0/1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.out_pc !== 32'h0 || bus.out_imm !== 32'h0 || bus.out_rd !== 5'd0 || bus.out_illegal !== 1'b0)
      begin errors++; $display("FAIL mr_data got pc=%h imm=%h rd=%0d ill=%0b exp 0", bus.out_pc, bus.out_imm, bus.out_rd, bus.out_illegal); end
    checks++; if (bus.out_alu_op !== ALU_ADD || bus.out_mem_op !== MEM_OP_NOP || bus.out_dest_src !== DEST_SRC_NONE)
      begin errors++; $display("FAIL mr_ctrl got alu=%0d mem=%0d dest=%0d exp 0/0/0", bus.out_alu_op, bus.out_mem_op, bus.out_dest_src); end
    #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mr_after got v=%0b exp 0", bus.out_valid); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_addi();
    test_store_load();
    test_alu_variants();
    test_back_to_back();
    test_illegal_flush();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
